ram_80x8_dp: RTL and testbench
==============================

// Module: ram_80x8_dp
// PURPOSE
//   80-entry x 8-bit dual-port RAM with one clock domain: one synchronous write port and one
//   asynchronous (combinational) read port.
//   Storage element of the single-clock FIFO; the FIFO controller drives the write/read pointers
//   and registers dout_ram itself.
//   Read data is therefore combinational: no read latency inside this block.
// PARAMETERS
//   DEPTH  80  number of words; legal addresses 0..DEPTH-1
//   WIDTH  8   data word width in bits
//   AW     7   address width in bits; must satisfy 2**AW >= DEPTH
// PORTS
//   clk      in   1      clock; all writes occur on its rising edge
//   rst_n    in   1      reset, asynchronous, active-low
//   wrt_sig  in   1      write enable, sampled on rising clk
//   addr_w   in   AW     write address
//   addr_r   in   AW     read address
//   din_ram  in   WIDTH  write data
//   dout_ram out  WIDTH  read data, combinational from addr_r
// BEHAVIOUR
// - Reset: while rst_n=0, all DEPTH words are cleared to 0 asynchronously; writes are ignored;
//   dout_ram=0. Deassertion is synchronised by the user; the first write takes effect on the first
//   rising clk with rst_n=1.
// - Write: on a rising clk with rst_n=1, wrt_sig=1 and addr_w<DEPTH: mem[addr_w] <= din_ram.
// - Write out of range: addr_w>=DEPTH (80..127) is a no-op; no aliasing or wrap.
// - Read: dout_ram = mem[addr_r] combinationally when addr_r<DEPTH.
// - Read out of range: addr_r>=DEPTH drives dout_ram = 0.
// - Read-during-write, same address, macro absent:
//   - before the clk edge, dout_ram shows the old word;
//   - after the edge it shows din_ram (read-first relative to the edge).
// - Simultaneous write and read at different addresses are fully independent.
// - Reset mid-operation: asserting rst_n=0 at any time clears contents immediately. A write whose
//   edge coincides with the reset assertion is lost.
// - No handshake, no flow control. Address wrap-around at DEPTH-1 -> 0 is the caller's
//   responsibility.
// - All arithmetic is unsigned. The range compare uses AW bits against DEPTH.
// CONFIGURATION
// - Macro RAM_80X8_DP_BYPASS_EN defined: write-through bypass.
//   - When wrt_sig=1, addr_w==addr_r and addr_w<DEPTH, dout_ram = din_ram combinationally in the
//     same cycle, before the edge.
//   - Reset still forces dout_ram = 0.
// - Macro undefined: no bypass; behaviour as stated above.
// STRUCTURE
// - Package ram_80x8_pkg holds:
//   - constants RAM_DEPTH=80, RAM_WIDTH=8, RAM_AW=7;
//   - typedefs ram_addr_t (logic [RAM_AW-1:0]) and ram_word_t (logic [RAM_WIDTH-1:0]).
// - One sub-module, ram_80x8_wdec: AW-bit write address plus enable -> DEPTH-bit one-hot row
//   enable. It drives all-zero for out-of-range addresses.
// - Top module holds the storage array, the per-row write logic and the read mux with range check.
// TESTING
// - Reset: preload words 0, 40 and 79 with nonzero data, then pulse rst_n=0 between edges.
//   -> dout_ram=0 immediately, and a readback of 0, 40 and 79 returns 8'h00.
// - Write/read: write 8'hA5 at addr 0, 8'h3C at addr 79, 8'h5A at addr 40.
//   -> with addr_r set to 0, 79 and 40, dout_ram = A5, 3C, 5A with no clock needed.
// - Out of range: write 8'hFF at addr_w=80 and at 127.
//   -> addr 0 and addr 79 keep their prior data; addr_r=80 and addr_r=127 read 8'h00.
// - Read-during-write: mem[10]=8'h11; wrt_sig=1, addr_w=addr_r=10, din_ram=8'h22.
//   -> without the macro, pre-edge 11 and post-edge 22; with RAM_80X8_DP_BYPASS_EN, pre-edge 22.
// - FIFO sweep: write values 0..79 to addresses 0..79, then read addresses 0..79.
//   -> each address returns its own index; wrt_sig=0 for one cycle leaves contents unchanged.
// - Disabled write: wrt_sig=0 with addr_w=5, din_ram=8'hEE over 3 edges -> mem[5] unchanged.

Source files
------------

// File: rtl/ram_80x8_pkg.sv
// Shared constants and types for the 80x8 dual-port FIFO storage RAM.
package ram_80x8_pkg;

  localparam int RAM_DEPTH = 80;
  localparam int RAM_WIDTH = 8;
  localparam int RAM_AW    = 7;

  typedef logic [RAM_AW-1:0]    ram_addr_t;
  typedef logic [RAM_WIDTH-1:0] ram_word_t;

endpackage : ram_80x8_pkg

// File: rtl/ram_80x8_wdec.sv
// Write-address decoder: address plus enable -> one-hot row enable, all-zero when out of range.
module ram_80x8_wdec
  import ram_80x8_pkg::*;
#(
  parameter int DEPTH = RAM_DEPTH,
  parameter int AW    = RAM_AW
) (
  input  logic             en,
  input  logic [AW-1:0]    addr,
  output logic [DEPTH-1:0] row_en
);

  // Rows exist only for 0..DEPTH-1, so addresses DEPTH..2**AW-1 match no row.
  always_comb begin
    // NOTE: default assignment first so the partially-assigned vector never infers a latch.
    row_en = '0;
    for (int i = 0; i < DEPTH; i++) begin
      row_en[i] = en && (addr == AW'(i));
    end
  end

endmodule : ram_80x8_wdec

// File: rtl/ram_80x8_dp.sv
// 80x8 RAM: synchronous write, combinational read, asynchronous clear on rst_n.
// Optional write-through bypass when RAM_80X8_DP_BYPASS_EN is defined.
module ram_80x8_dp
  import ram_80x8_pkg::*;
#(
  parameter int DEPTH = RAM_DEPTH,
  parameter int WIDTH = RAM_WIDTH,
  parameter int AW    = RAM_AW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wrt_sig,
  input  logic [AW-1:0]    addr_w,
  input  logic [AW-1:0]    addr_r,
  input  logic [WIDTH-1:0] din_ram,
  output logic [WIDTH-1:0] dout_ram
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] row_en;
  logic             rd_in_range;

  ram_80x8_wdec #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_wdec (
    .en     (wrt_sig),
    .addr   (addr_w),
    .row_en (row_en)
  );

  // NOTE: this array is cleared by reset because the FIFO relies on reading zeros after reset;
  // that forces flops instead of a RAM macro, which is acceptable at 80x8.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (row_en[i]) begin
          mem[i] <= din_ram;
        end
      end
    end
  end

  assign rd_in_range = (addr_r <= LAST_ADDR);

  always_comb begin
    dout_ram = '0;
    if (rst_n && rd_in_range) begin
      dout_ram = mem[addr_r];
`ifdef RAM_80X8_DP_BYPASS_EN
      // Same-cycle write-through: the row being written is shown before the edge.
      if (wrt_sig && (addr_w == addr_r)) begin
        dout_ram = din_ram;
      end
`endif
    end
  end

endmodule : ram_80x8_dp

// File: tb/tb_ram_80x8_dp.sv
// Self-checking bench for ram_80x8_dp: directed cases plus randomized traffic vs. an array model.
module tb_ram_80x8_dp;
  import ram_80x8_pkg::*;

  logic      clk = 1'b0;
  logic      rst_n;
  logic      wrt_sig;
  ram_addr_t addr_w;
  ram_addr_t addr_r;
  ram_word_t din_ram;
  ram_word_t dout_ram;

  int total = 0;
  int bad   = 0;

  // Reference contents: what each word should hold after every edge so far.
  ram_word_t model_mem [RAM_DEPTH];

  ram_80x8_dp dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wrt_sig  (wrt_sig),
    .addr_w   (addr_w),
    .addr_r   (addr_r),
    .din_ram  (din_ram),
    .dout_ram (dout_ram)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input ram_word_t got, input ram_word_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected combinational read for the current inputs.
  function automatic ram_word_t exp_read(input int a);
    if (!rst_n || a >= RAM_DEPTH) return '0;
`ifdef RAM_80X8_DP_BYPASS_EN
    if (wrt_sig && int'(addr_w) == a) return din_ram;
`endif
    return model_mem[a];
  endfunction

  // Apply the pending write to the model, then advance to 1 ns past the next rising edge.
  task automatic step();
    if (rst_n && wrt_sig && int'(addr_w) < RAM_DEPTH) model_mem[addr_w] = din_ram;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    wrt_sig = 1'b1;
    addr_w  = ram_addr_t'(a);
    din_ram = ram_word_t'(d);
    step();
    wrt_sig = 1'b0;
  endtask

  // Only used with wrt_sig=0, so drifting across an edge is harmless.
  task automatic rd_chk(input string tag, input int a);
    addr_r = ram_addr_t'(a);
    #1;
    check(tag, dout_ram, exp_read(a));
  endtask

  initial begin
    rst_n   = 1'b0;
    wrt_sig = 1'b0;
    addr_w  = '0;
    addr_r  = '0;
    din_ram = '0;
    for (int i = 0; i < RAM_DEPTH; i++) model_mem[i] = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_dout", dout_ram, 8'h00);
    rst_n = 1'b1;
    step();

    // Basic write/read at both ends and the middle, no clock needed for the reads.
    wr(0, 8'hA5);
    wr(79, 8'h3C);
    wr(40, 8'h5A);
    addr_r = 7'd0;  #1; check("rd_0",  dout_ram, 8'hA5);
    addr_r = 7'd79; #1; check("rd_79", dout_ram, 8'h3C);
    addr_r = 7'd40; #1; check("rd_40", dout_ram, 8'h5A);
    step();

    // Out-of-range writes must not alias onto any row.
    wr(80, 8'hFF);
    wr(127, 8'hFF);
    addr_r = 7'd0;   #1; check("oor_keep_0",  dout_ram, 8'hA5);
    addr_r = 7'd79;  #1; check("oor_keep_79", dout_ram, 8'h3C);
    addr_r = 7'd80;  #1; check("oor_rd_80",   dout_ram, 8'h00);
    addr_r = 7'd127; #1; check("oor_rd_127",  dout_ram, 8'h00);
    step();

    // Read-during-write at the same address.
    wr(10, 8'h11);
    wrt_sig = 1'b1;
    addr_w  = 7'd10;
    addr_r  = 7'd10;
    din_ram = 8'h22;
    #1;
`ifdef RAM_80X8_DP_BYPASS_EN
    check("rdw_pre", dout_ram, 8'h22);
`else
    check("rdw_pre", dout_ram, 8'h11);
`endif
    step();
    check("rdw_post", dout_ram, 8'h22);
    wrt_sig = 1'b0;
    step();

    // Disabled write over three edges.
    wr(5, 8'h77);
    wrt_sig = 1'b0;
    addr_w  = 7'd5;
    din_ram = 8'hEE;
    repeat (3) step();
    addr_r = 7'd5; #1; check("wdis_5", dout_ram, 8'h77);
    step();

    // FIFO sweep, then an idle cycle, then a few re-reads.
    for (int i = 0; i < RAM_DEPTH; i++) wr(i, i);
    for (int i = 0; i < RAM_DEPTH; i++) begin
      addr_r = ram_addr_t'(i);
      #1;
      check($sformatf("sweep_%0d", i), dout_ram, ram_word_t'(i));
    end
    step();
    wrt_sig = 1'b0;
    step();
    rd_chk("idle_0", 0);
    rd_chk("idle_41", 41);
    rd_chk("idle_79", 79);
    step();

    // Reset mid-operation: preload, then assert rst_n between edges.
    wr(0, 8'hC1);
    wr(40, 8'hC2);
    wr(79, 8'hC3);
    addr_r = 7'd40;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_dout_now", dout_ram, 8'h00);
    for (int i = 0; i < RAM_DEPTH; i++) model_mem[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    rd_chk("rst_rd_0", 0);
    rd_chk("rst_rd_40", 40);
    rd_chk("rst_rd_79", 79);
    step();

    // Randomized traffic, with frequent same-address collisions.
    for (int n = 0; n < 400; n++) begin
      wrt_sig = 1'($urandom_range(0, 1));
      addr_w  = ram_addr_t'($urandom_range(0, 127));
      din_ram = ram_word_t'($urandom);
      if ($urandom_range(0, 3) == 0) addr_r = addr_w;
      else addr_r = ram_addr_t'($urandom_range(0, 127));
      #1;
      check($sformatf("rand_%0d", n), dout_ram, exp_read(int'(addr_r)));
      step();
    end
    wrt_sig = 1'b0;

    // Final full readback of the model contents.
    for (int i = 0; i < RAM_DEPTH; i++) rd_chk($sformatf("final_%0d", i), i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_ram_80x8_dp
